// File: rtl/psum_quant_pkg.sv
// Shared widths, lane types and the rounding/saturation arithmetic used by the
// psum_quant output quantiser.
package psum_quant_pkg;

  localparam int DWIDTH = 32;
  localparam int QWIDTH = 8;
  localparam int PACK   = 4;
  localparam int AWIDTH = 3;
  localparam int CWIDTH = $clog2(PACK);
  localparam int FWIDTH = PACK*QWIDTH + PACK + 1;

  typedef logic signed [QWIDTH-1:0] lane_t;
  typedef logic signed [DWIDTH:0]   sum_t;
  typedef logic signed [DWIDTH+1:0] rnd_t;

  localparam lane_t QMAX = lane_t'(2**(QWIDTH-1) - 1);
  localparam lane_t QMIN = lane_t'(-(2**(QWIDTH-1)));

  // Round half up: add half an LSB of the result, then shift arithmetically.
  function automatic rnd_t round_shift(input sum_t s, input logic [4:0] sh);
    rnd_t ext;
    rnd_t half;
    ext  = rnd_t'(s);
    half = '0;
    if (sh == 5'd0) return ext;
    half[sh - 5'd1] = 1'b1;
    return (ext + half) >>> sh;
  endfunction

  function automatic lane_t saturate(input rnd_t r, input logic relu);
    rnd_t v;
    v = r;
    if (relu && v[DWIDTH+1]) v = '0;
    if (v > rnd_t'(QMAX)) return QMAX;
    if (v < rnd_t'(QMIN)) return QMIN;
    return v[QWIDTH-1:0];
  endfunction

endpackage

// File: rtl/psum_quant_if.sv
// Output word stream of psum_quant toward the SRAM writer.
interface psum_quant_if;
  import psum_quant_pkg::*;

  // A word transfers on every clock edge where out_valid and out_ready are both 1;
  // out_valid never waits on out_ready, and payload is stable while out_valid holds.
  logic                    out_valid;
  logic [PACK*QWIDTH-1:0]  out_data;
  logic [PACK-1:0]         out_keep;
  logic                    out_last;
  logic                    out_ready;

  modport master (output out_valid, out_data, out_keep, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_keep, out_last, output out_ready);

endinterface

// File: rtl/q_outfifo.sv
// First-word-fall-through word buffer; a push into a full FIFO is accepted only
// when the head is popped in the same cycle, otherwise it is reported as a drop.
module q_outfifo #(
  parameter int W  = 37,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          wr_en;
  logic          rd_en;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign drop  = push & full & ~rd_en;
  // Empty head reads as zero so the output bus idles at its reset value.
  assign dout  = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (rd_en) rp <= rp + AW'(1);
      if (wr_en && !rd_en)      cnt <= cnt + (AW+1)'(1);
      else if (!wr_en && rd_en) cnt <= cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= din;
  end

endmodule

// File: rtl/psum_quant.sv
// Bias, rounding shift, ReLU and int8 saturation of accumulator sums, packed
// four lanes per word into an output FIFO.
module psum_quant
  import psum_quant_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cfg_valid,
  input  logic signed [DWIDTH-1:0] cfg_bias,
  input  logic [4:0]               cfg_shift,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  input  logic signed [DWIDTH-1:0] in_data,
  input  logic                     in_last,
  psum_quant_if.master             ob,
  output logic                     overflow,
  output logic                     busy
);

  logic signed [DWIDTH-1:0] bias_q;
  logic [4:0]               shift_q;
  logic                     relu_q;

  logic                     s1_valid, s1_last;
  sum_t                     s1_sum;
  logic                     s2_valid, s2_last;
  rnd_t                     s2_r;

  logic [CWIDTH-1:0]        lane_cnt;
  logic [PACK*QWIDTH-1:0]   word_q;
  logic [PACK-1:0]          keep_q;

  lane_t                    lane;
  logic [PACK*QWIDTH-1:0]   nxt_word;
  logic [PACK-1:0]          nxt_keep;
  logic                     close;

  logic [FWIDTH-1:0]        fifo_dout;
  logic                     fifo_full, fifo_empty, fifo_drop, pop;

  // S3 is combinational: the saturated lane goes straight into the packer and FIFO.
  always_comb begin
    lane     = saturate(s2_r, relu_q);
    nxt_word = word_q;
    nxt_keep = keep_q;
    nxt_word[lane_cnt*QWIDTH +: QWIDTH] = lane;
    nxt_keep[lane_cnt] = 1'b1;
    close    = s2_valid & (s2_last | (lane_cnt == CWIDTH'(PACK-1)));
  end

  assign pop  = ob.out_valid & ob.out_ready;
  assign busy = s1_valid | s2_valid | (|keep_q) | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bias_q   <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_r     <= '0;
      lane_cnt <= '0;
      word_q   <= '0;
      keep_q   <= '0;
      overflow <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
      s1_sum   <= sum_t'(in_data) + sum_t'(bias_q);
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_r     <= round_shift(s1_sum, shift_q);
      if (s2_valid) begin
        if (close) begin
          lane_cnt <= '0;
          word_q   <= '0;
          keep_q   <= '0;
        end else begin
          lane_cnt <= lane_cnt + CWIDTH'(1);
          word_q   <= nxt_word;
          keep_q   <= nxt_keep;
        end
      end
      // busy=0 implies no push this cycle, so a config write and a drop never collide.
      if (cfg_valid && !busy) begin
        bias_q   <= cfg_bias;
        shift_q  <= cfg_shift;
        relu_q   <= cfg_relu;
        overflow <= 1'b0;
      end else if (fifo_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  q_outfifo #(.W(FWIDTH), .AW(AWIDTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (close),
    .din   ({nxt_word, nxt_keep, s2_last}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign ob.out_valid = ~fifo_empty;
  assign ob.out_data  = fifo_dout[FWIDTH-1 -: PACK*QWIDTH];
  assign ob.out_keep  = fifo_dout[PACK:1];
  assign ob.out_last  = fifo_dout[0];

endmodule

// File: tb/tb_psum_quant.sv
// Directed-vector bench for psum_quant: a quantisation table plus hand-written
// backpressure, overflow, reset and config-gating sequences.
module tb_psum_quant;
  import psum_quant_pkg::*;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cfg_valid = 1'b0;
  logic signed [31:0] cfg_bias = '0;
  logic [4:0]        cfg_shift = '0;
  logic              cfg_relu = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [31:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              overflow;
  logic              busy;

  psum_quant_if ob();

  psum_quant dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_valid (cfg_valid),
    .cfg_bias  (cfg_bias),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .ob        (ob),
    .overflow  (overflow),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0]      bias;
    logic [4:0]       shift;
    logic             relu;
    logic [3:0][31:0] d;
    int               n;
    logic             last;
    logic [31:0]      exp_data;
    logic [3:0]       exp_keep;
    logic             exp_last;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [31:0] b, input logic [4:0] s, input logic r);
    cfg_bias  = b;
    cfg_shift = s;
    cfg_relu  = r;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 100) begin
      tick();
      t++;
    end
    n_vec++;
    if (busy) begin
      n_err++;
      $display("FAIL %s: busy still 1 after 100 cycles, expected 0", name);
    end
  endtask

  // Pops with out_ready held high and compares each word against exp_q.
  task automatic drain(input string name, input int n_exp);
    int got;
    got = 0;
    ob.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (ob.out_valid) begin
        if (exp_q.size() > 0) check($sformatf("%s_word%0d", name, got), ob.out_data, exp_q.pop_front());
        got++;
      end
      tick();
    end
    ob.out_ready = 1'b0;
    check($sformatf("%s_count", name), 32'(got), 32'(n_exp));
  endtask

  function automatic logic [31:0] ramp_word(input int k);
    return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
  endfunction

  // ---------------- test ----------------
  initial begin
    vt[0] = '{32'd10, 5'd2, 1'b0, {32'd100, 32'd100, 32'd100, 32'd100}, 4, 1'b0,
              32'h1C1C1C1C, 4'b1111, 1'b0};
    vt[1] = '{32'd0, 5'd2, 1'b0, {32'd2, -32'd1000, 32'd1000, -32'd6}, 4, 1'b0,
              32'h01807FFF, 4'b1111, 1'b0};
    vt[2] = '{32'd0, 5'd0, 1'b1, {32'd0, 32'd0, 32'd7, -32'd5}, 2, 1'b1,
              32'h00000700, 4'b0011, 1'b1};
    // 33-bit sums near the int32 limits with the maximum shift.
    vt[3] = '{32'h7FFFFFFF, 5'd31, 1'b0, {32'd0, 32'h40000001, 32'h80000000, 32'h7FFFFFFF}, 4, 1'b1,
              32'h01020002, 4'b1111, 1'b1};
    // -2^31 + -2^31 must not wrap to zero.
    vt[4] = '{32'h80000000, 5'd0, 1'b0, {32'd0, 32'd0, 32'h7FFFFFFF, 32'h80000000}, 2, 1'b1,
              32'h0000FF80, 4'b0011, 1'b1};
    vt[5] = '{32'd0, 5'd1, 1'b1, {32'd256, 32'd255, -32'd3, 32'd3}, 4, 1'b0,
              32'h7F7F0002, 4'b1111, 1'b0};
    vt[6] = '{32'hFFFFFFF8, 5'd4, 1'b0, {32'd0, 32'd0, 32'd0, 32'd40}, 1, 1'b1,
              32'h00000002, 4'b0001, 1'b1};

    ob.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(ob.out_valid), 32'd0);
    check("rst_out_data", ob.out_data, 32'd0);
    check("rst_out_keep", 32'(ob.out_keep), 32'd0);
    check("rst_out_last", 32'(ob.out_last), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    tick();

    // ---- table-driven quantisation vectors ----
    for (int v = 0; v < 7; v++) begin
      wait_idle($sformatf("v%0d_idle", v));
      load_cfg(vt[v].bias, vt[v].shift, vt[v].relu);
      for (int k = 0; k < vt[v].n; k++) begin
        send(vt[v].d[k], vt[v].last && (k == vt[v].n - 1));
        if (k == 0) check($sformatf("v%0d_busy_rise", v), 32'(busy), 32'd1);
      end
      tick();
      check($sformatf("v%0d_valid_n2", v), 32'(ob.out_valid), 32'd0);
      tick();
      check($sformatf("v%0d_valid_n3", v), 32'(ob.out_valid), 32'd1);
      check($sformatf("v%0d_data", v), ob.out_data, vt[v].exp_data);
      check($sformatf("v%0d_keep", v), 32'(ob.out_keep), 32'(vt[v].exp_keep));
      check($sformatf("v%0d_last", v), 32'(ob.out_last), 32'(vt[v].exp_last));
      ob.out_ready = 1'b1;
      tick();
      ob.out_ready = 1'b0;
      check($sformatf("v%0d_popped", v), 32'(ob.out_valid), 32'd0);
    end

    // ---- backpressure: 9 words into an 8-deep FIFO ----
    wait_idle("ovf_idle");
    load_cfg(32'd0, 5'd0, 1'b0);
    for (int i = 0; i < 36; i++) send(32'(i), 1'b0);
    check("ovf_n1", 32'(overflow), 32'd0);
    tick();
    check("ovf_n2", 32'(overflow), 32'd0);
    tick();
    check("ovf_n3", 32'(overflow), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) exp_q.push_back(ramp_word(k));
    drain("ovf_drain", 8);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_idle_after", 32'(busy), 32'd0);
    load_cfg(32'd0, 5'd0, 1'b0);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // ---- full FIFO with a pop in the same cycle as the 9th push ----
    for (int i = 0; i < 36; i++) send(32'(i), 1'b0);
    tick();
    ob.out_ready = 1'b1;
    tick();
    ob.out_ready = 1'b0;
    tick();
    check("fullpop_no_ovf", 32'(overflow), 32'd0);
    for (int k = 1; k < 9; k++) exp_q.push_back(ramp_word(k));
    drain("fullpop_drain", 8);
    check("fullpop_no_ovf_end", 32'(overflow), 32'd0);

    // ---- reset with 3 words queued and 2 samples in flight ----
    wait_idle("rst2_idle");
    for (int i = 0; i < 14; i++) send(32'(i), 1'b0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rst2_out_valid", 32'(ob.out_valid), 32'd0);
    check("rst2_out_data", ob.out_data, 32'd0);
    check("rst2_out_keep", 32'(ob.out_keep), 32'd0);
    check("rst2_out_last", 32'(ob.out_last), 32'd0);
    check("rst2_overflow", 32'(overflow), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("rst2_no_stale", 32'(ob.out_valid), 32'd0);
    check("rst2_still_idle", 32'(busy), 32'd0);

    // ---- config write while busy is ignored ----
    load_cfg(32'd0, 5'd0, 1'b0);
    send(32'd5, 1'b0);
    check("gate_busy", 32'(busy), 32'd1);
    load_cfg(32'd100, 5'd3, 1'b1);
    send(32'd5, 1'b0);
    send(32'd5, 1'b0);
    send(32'd5, 1'b1);
    begin
      int t;
      t = 0;
      while (!ob.out_valid && t < 20) begin
        tick();
        t++;
      end
    end
    check("gate_valid", 32'(ob.out_valid), 32'd1);
    check("gate_data", ob.out_data, 32'h05050505);
    check("gate_keep", 32'(ob.out_keep), 32'hF);
    check("gate_last", 32'(ob.out_last), 32'd1);
    ob.out_ready = 1'b1;
    tick();
    ob.out_ready = 1'b0;
    wait_idle("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
